// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared state encoding, cycle conversion and channel scaling for the NeoPixel transmitter
package neopixel_pkg;

    localparam int CHAN_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Floor conversion; kHz first keeps the intermediate product small.
    function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz / 1000) * ns / 1_000_000);
    endfunction

    function automatic logic [CHAN_BITS-1:0] scale_chan(input logic [CHAN_BITS-1:0] c,
                                                        input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

endpackage

// File: rtl/neopixel_bit_timer.sv
// rtl/neopixel_bit_timer.sv - per-bit cycle counter and registered high-time comparator
module neopixel_bit_timer #(
    parameter int T0H_CYC  = 4,
    parameter int T1H_CYC  = 9,
    parameter int TBIT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic bit_val,
    output logic d_out,
    output logic bit_end
);

    localparam int CW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;

    logic [CW-1:0] cnt;
    int            cnt_nxt;
    int            high_cyc;

    assign cnt_nxt  = int'(cnt) + 1;
    assign high_cyc = bit_val ? T1H_CYC : T0H_CYC;
    assign bit_end  = run && (int'(cnt) == TBIT_CYC - 1);

    // d_out tracks (cnt < high) in the same cycle; every bit starts high since T0H_CYC >= 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            d_out <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            d_out <= 1'b1;
        end else if (run && !bit_end) begin
            cnt   <= cnt + CW'(1);
            d_out <= (cnt_nxt < high_cyc);
        end else begin
            cnt   <= '0;
            d_out <= 1'b0;
        end
    end

endmodule

// File: rtl/neopixel_strip_tx.sv
// rtl/neopixel_strip_tx.sv - NeoPixel frame serialiser; NEOPIXEL_BRIGHTNESS_EN adds a brightness scaling input
module neopixel_strip_tx
    import neopixel_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int PIX_BITS  = 24,
    parameter int T0H_NS    = 400,
    parameter int T1H_NS    = 800,
    parameter int TBIT_NS   = 1250,
    parameter int TLATCH_US = 80
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PIX_BITS-1:0] pixel_data,
    input  logic                pixel_last,
    input  logic                pixel_valid,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    output logic                pixel_ready,
    output logic                d_out,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun
);

    localparam int T0H_CYC    = ns_to_cyc(CLK_HZ, T0H_NS);
    localparam int T1H_CYC    = ns_to_cyc(CLK_HZ, T1H_NS);
    localparam int TBIT_CYC   = ns_to_cyc(CLK_HZ, TBIT_NS);
    localparam int TLATCH_CYC = ns_to_cyc(CLK_HZ, longint'(TLATCH_US) * 1000);
    localparam int IW         = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
    localparam int LW         = (TLATCH_CYC > 1) ? $clog2(TLATCH_CYC) : 1;

    generate
        if (T0H_CYC < 1 || T1H_CYC <= T0H_CYC || TBIT_CYC <= T1H_CYC) begin : g_bad_timing
            $error("neopixel_strip_tx: bit timing does not satisfy 1 <= T0H < T1H < TBIT cycles");
        end
        if (PIX_BITS % CHAN_BITS != 0 || PIX_BITS < CHAN_BITS) begin : g_bad_width
            $error("neopixel_strip_tx: PIX_BITS must be a non-zero multiple of 8");
        end
        if (TLATCH_CYC < 1) begin : g_bad_latch
            $error("neopixel_strip_tx: latch period shorter than one cycle");
        end
    endgenerate

    state_t              state, state_nxt;
    logic [PIX_BITS-1:0] sh;
    logic [PIX_BITS-1:0] word_in;
    logic [IW-1:0]       bit_idx;
    logic [LW-1:0]       lcnt;
    logic                last_q;
    logic                latch_frame;
    logic                accept;
    logic                bit_end;
    logic                last_bit_end;
    logic                latch_end;
    logic                timer_start;

    assign accept       = pixel_valid && pixel_ready;
    assign last_bit_end = bit_end && (bit_idx == '0);
    assign latch_end    = (state == ST_LATCH) && (lcnt == LW'(TLATCH_CYC - 1));
    assign timer_start  = accept || (bit_end && (bit_idx != '0));

`ifdef NEOPIXEL_BRIGHTNESS_EN
    always_comb begin
        word_in = pixel_data;
        for (int c = 0; c < PIX_BITS / CHAN_BITS; c++) begin
            word_in[c*CHAN_BITS +: CHAN_BITS] = scale_chan(pixel_data[c*CHAN_BITS +: CHAN_BITS], brightness);
        end
    end
`else
    assign word_in = pixel_data;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_LATCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_BIT;
            ST_BIT:   if (last_bit_end && !accept) state_nxt = last_q ? ST_LATCH : ST_IDLE;
            ST_LATCH: if (latch_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_LATCH;
        endcase
    end

    // Ready opens in BIT only on the final cycle of the final bit, so words chain without a gap.
    always_comb begin
        pixel_ready = (state == ST_IDLE) || ((state == ST_BIT) && last_bit_end);
        busy        = (state != ST_IDLE);
        frame_done  = latch_end && latch_frame;
        underrun    = (state == ST_BIT) && last_bit_end && !accept && !last_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sh          <= '0;
            bit_idx     <= '0;
            last_q      <= 1'b0;
            lcnt        <= '0;
            latch_frame <= 1'b0;
        end else begin
            if (accept) begin
                sh      <= word_in;
                last_q  <= pixel_last;
                bit_idx <= IW'(PIX_BITS - 1);
            end else if (bit_end && (bit_idx != '0)) begin
                sh      <= sh << 1;
                bit_idx <= bit_idx - IW'(1);
            end
            if ((state == ST_LATCH) && !latch_end) lcnt <= lcnt + LW'(1);
            else                                   lcnt <= '0;
            // Reset enters LATCH with latch_frame clear, so only a real frame end reports done.
            if ((state == ST_BIT) && (state_nxt == ST_LATCH)) latch_frame <= 1'b1;
            else if (latch_end)                              latch_frame <= 1'b0;
        end
    end

    neopixel_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_timer (
        .clk     (CLK),
        .rst     (RST),
        .start   (timer_start),
        .run     (state == ST_BIT),
        .bit_val (sh[PIX_BITS-1]),
        .d_out   (d_out),
        .bit_end (bit_end)
    );

endmodule
